// File: rtl/mem_port_arb.sv
// Arbiter sharing one variable-latency memory port between instruction fetch (I) and data (D).
// Optional ARB_TIMEOUT_EN aborts a transaction whose ack never arrives and pulses err.
module mem_port_arb #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            err
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
  localparam logic [DW-1:0] Nop = DW'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic            i_rvalid_q, i_rvalid_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            busy_q, busy_d;
  logic            i_win, d_win;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = 1'b0;
`endif

    // D wins ties until it has starved I for STARVE_MAX contested grants.
    i_win = i_req && (!d_req || (starve_q == StarveMax));
    d_win = d_req && !i_win;
    i_gnt = (state_q == StIdle) && i_win;
    d_gnt = (state_q == StIdle) && d_win;

    unique case (state_q)
      StIdle: begin
        if (i_gnt) begin
          state_d     = StBusyI;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          starve_d    = '0;
`ifdef ARB_TIMEOUT_EN
          wait_d      = '0;
`endif
        end else if (d_gnt) begin
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          if (i_req && (starve_q != StarveMax)) starve_d = starve_q + SW'(1);
`ifdef ARB_TIMEOUT_EN
          wait_d      = '0;
`endif
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (state_q == StBusyI) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (int'(wait_q) + 1 >= int'(TIMEOUT)) begin
          // Abort: report completion with safe default data alongside err.
          state_d   = StIdle;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == StBusyI) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = Nop;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = '0;
          end
        end else begin
          wait_d = wait_q + WW'(1);
`endif
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= Nop;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rvalid_q  <= i_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb; timeout scenario compiled with ARB_TIMEOUT_EN.
module tb_mem_port_arb;

  logic        clk, rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy, err;

  int checks = 0;
  int failures = 0;

  mem_port_arb #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ack = 0; mem_rdata = 0;
    #12;
    checks++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0000", {i_gnt, d_gnt, i_rvalid, d_rvalid}); end
    checks++; if (i_rdata !== 32'h13) begin
      failures++; $display("FAIL reset_i_rdata got=%h exp=00000013", i_rdata); end
    checks++; if (d_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, err} !== '0) begin
      failures++; $display("FAIL reset_mem got req=%b busy=%b err=%b addr=%h exp all 0",
                           mem_req, busy, err, mem_addr); end
    @(negedge clk);
    rst = 1'b1;
    next();
  endtask

  task automatic test_fetch();
    i_req = 1; i_addr = 32'h10;
    #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL fetch_gnt got=%b exp=10", {i_gnt, d_gnt}); end
    next();
    i_req = 0; i_addr = 32'hFFFF_FFFF;
    checks++; if ({mem_req, mem_we, busy} !== 3'b101 || mem_addr !== 32'h10) begin
      failures++; $display("FAIL fetch_mem got req/we/busy=%b addr=%h exp=101 addr=10",
                           {mem_req, mem_we, busy}, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    next();
    mem_ack = 0; mem_rdata = 0;
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0050_0093) begin
      failures++; $display("FAIL fetch_rvalid got v=%b d=%h exp v=1 d=00500093", i_rvalid, i_rdata); end
    checks++; if ({mem_req, busy, d_rvalid} !== 3'b000) begin
      failures++; $display("FAIL fetch_done got=%b exp=000", {mem_req, busy, d_rvalid}); end
    next();
    checks++; if (i_rvalid !== 1'b0) begin
      failures++; $display("FAIL fetch_pulse got=%b exp=0", i_rvalid); end
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b1111;
    #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b01) begin
      failures++; $display("FAIL store_gnt got=%b exp=01", {i_gnt, d_gnt}); end
    next();
    d_req = 0; d_we = 0; d_addr = 32'h5; d_wdata = 32'h5; d_be = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h100 ||
                    mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'hF || d_rvalid !== 1'b0) begin
        failures++; $display("FAIL store_payload k=%0d got req=%b we=%b a=%h w=%h be=%h rv=%b",
                             k, mem_req, mem_we, mem_addr, mem_wdata, mem_be, d_rvalid); end
      if (k == 3) begin mem_ack = 1; mem_rdata = 32'h1234_5678; end
      next();
    end
    mem_ack = 0; mem_rdata = 0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL store_done got rv=%b d=%h req=%b exp rv=1 d=0 req=0",
                           d_rvalid, d_rdata, mem_req); end
    next();
  endtask

  task automatic test_contention();
    logic exp_i, prev_i;
    prev_i = 0;
    i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h400;
    for (int t = 0; t < 10; t++) begin
      exp_i = (t % 5 == 4);
      #1;
      checks++; if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin
        failures++; $display("FAIL contend_gnt t=%0d got=%b exp=%b", t, {i_gnt, d_gnt},
                             {exp_i, ~exp_i}); end
      if (t > 0) begin
        checks++; if ({i_rvalid, d_rvalid} !== {prev_i, ~prev_i}) begin
          failures++; $display("FAIL contend_rvalid t=%0d got=%b exp=%b", t,
                               {i_rvalid, d_rvalid}, {prev_i, ~prev_i}); end
      end
      next();
      mem_ack = 1; mem_rdata = 32'(t);
      next();
      mem_ack = 0;
      prev_i = exp_i;
    end
    i_req = 0; d_req = 0;
    #1;
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'd9 || d_rdata !== 32'd8) begin
      failures++; $display("FAIL contend_data got irv=%b i=%h d=%h exp irv=1 i=9 d=8",
                           i_rvalid, i_rdata, d_rdata); end
    next();
  endtask

  task automatic test_late_ack();
    mem_ack = 1; mem_rdata = 32'h5555;
    next();
    checks++; if ({i_rvalid, d_rvalid, busy, mem_req} !== 4'b0) begin
      failures++; $display("FAIL late_ack_idle got=%b exp=0000", {i_rvalid, d_rvalid, busy, mem_req}); end
    i_req = 1; i_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h300;
    #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b01) begin
      failures++; $display("FAIL late_ack_gnt got=%b exp=01", {i_gnt, d_gnt}); end
    next();
    i_req = 0; d_req = 0; mem_ack = 0;
    checks++; if (busy !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin
      failures++; $display("FAIL late_ack_busy got busy=%b a=%h we=%b", busy, mem_addr, mem_we); end
    mem_ack = 1; mem_rdata = 32'hCAFE;
    next();
    mem_ack = 0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE) begin
      failures++; $display("FAIL late_ack_load got rv=%b d=%h exp rv=1 d=cafe", d_rvalid, d_rdata); end
    next();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1; d_be = 4'b0001;
    #1;
    checks++; if (d_gnt !== 1'b1) begin
      failures++; $display("FAIL rstmid_gnt got=%b exp=1", d_gnt); end
    next();
    d_req = 0;
    next();
    next();
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({mem_req, busy, d_rvalid} !== 3'b000) begin
      failures++; $display("FAIL rstmid_async got=%b exp=000", {mem_req, busy, d_rvalid}); end
    @(posedge clk);
    #2;
    @(negedge clk);
    rst = 1'b1;
    next();
    i_req = 1; i_addr = 32'h50;
    #1;
    checks++; if (i_gnt !== 1'b1 || d_rvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_regrant got gnt=%b drv=%b exp 1 0", i_gnt, d_rvalid); end
    next();
    i_req = 0; mem_ack = 1; mem_rdata = 32'hAB;
    next();
    mem_ack = 0;
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hAB || d_rvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_fetch got rv=%b d=%h drv=%b", i_rvalid, i_rdata, d_rvalid); end
    next();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    i_req = 1; i_addr = 32'h40;
    #1;
    checks++; if (i_gnt !== 1'b1) begin
      failures++; $display("FAIL to_gnt got=%b exp=1", i_gnt); end
    next();
    i_req = 0;
    for (int k = 0; k < 8; k++) begin
      checks++; if ({mem_req, err, i_rvalid} !== 3'b100) begin
        failures++; $display("FAIL to_wait k=%0d got=%b exp=100", k, {mem_req, err, i_rvalid}); end
      next();
    end
    checks++; if ({err, i_rvalid, busy, mem_req} !== 4'b1100 || i_rdata !== 32'h13) begin
      failures++; $display("FAIL to_abort got e/rv/busy/req=%b d=%h exp 1100 d=13",
                           {err, i_rvalid, busy, mem_req}, i_rdata); end
    i_req = 1; i_addr = 32'h44;
    #1;
    checks++; if (i_gnt !== 1'b1) begin
      failures++; $display("FAIL to_regrant got=%b exp=1", i_gnt); end
    next();
    i_req = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin mem_ack = 1; mem_rdata = 32'h77; end
      next();
    end
    mem_ack = 0;
    checks++; if ({err, i_rvalid} !== 2'b01 || i_rdata !== 32'h77) begin
      failures++; $display("FAIL to_edge_ack got err/rv=%b d=%h exp 01 d=77", {err, i_rvalid}, i_rdata); end
    next();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_late_ack();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter that shares one single-ported, variable-latency memory between the pipelined RV32I core's instruction-fetch port (I, read-only) and its MEM-stage data port (D, load/store). Each requester gets a grant/completion handshake; the arbiter registers the winning request, drives the shared memory handshake and returns read data. It sits between the PLCPU top level and the unified memory model, and its `i_gnt`/`d_gnt` and `busy` outputs feed the core's stall logic.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (byte enables are `DW/8` bits)
- `STARVE_MAX`, 4, number of consecutive contested D grants after which I wins one tie
- `TIMEOUT`, 255, maximum number of wait cycles before a transaction is aborted (used only with `ARB_TIMEOUT_EN`)

- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`
- `i_addr`  in  AW  fetch address
- `i_gnt`  out  1  fetch request accepted in this cycle (combinational)
- `i_rvalid`  out  1  one-cycle pulse: `i_rdata` is valid
- `i_rdata`  out  DW  fetched instruction
- `d_req`  in  1  data request; held with its payload until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_be`  in  DW/8  store byte enables
- `d_gnt`  out  1  data request accepted in this cycle (combinational)
- `d_rvalid`  out  1  one-cycle completion pulse for a load or a store
- `d_rdata`  out  DW  load data
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/1/AW/DW/DW/8  shared memory request, driven from internal registers
- `mem_ack`  in  1  memory completes the current request at this edge
- `mem_rdata`  in  DW  read data, valid when `mem_ack` is high
- `busy`  out  1  a transaction is in flight (state ≠ IDLE)
- `err`  out  1  one-cycle pulse when a transaction is aborted on timeout

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- In IDLE the arbiter picks a winner:
  - Only one requester active: that requester wins.
  - Both active: D wins, unless `starve_cnt == STARVE_MAX`, in which case I wins.
  - The winner's `*_gnt` is high in that cycle only.
- On the grant edge:
  - The request is latched into the `mem_*` registers.
  - The FSM moves to BUSY_I or BUSY_D.
  - `mem_req` goes high in the next cycle and stays high, with a stable payload, until `mem_ack`.
- When `mem_ack` is sampled high in BUSY_x:
  - `mem_req` drops and the FSM returns to IDLE.
  - The owner's `*_rvalid` pulses for the next cycle.
  - Loads and fetches capture `mem_rdata` into `*_rdata`. Stores leave `d_rdata` unchanged.
- `mem_ack` is ignored in IDLE. Grants are never issued outside IDLE.
- `starve_cnt` (width `$clog2(STARVE_MAX+1)`, minimum 1 bit):
  - Increments, saturating at `STARVE_MAX`, on each D grant made while `i_req` is high.
  - Clears on every I grant.
  - Unchanged otherwise.
  - With `STARVE_MAX = 0`, I wins every tie.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately, `mem_req` drops and the in-flight request is discarded with no `rvalid`. Memory must tolerate an abandoned request.

## Timing
- Reset values: every output is 0, except `i_rdata` and `d_rdata` which reset to `32'h0000_0013` (NOP) and 0. `starve_cnt` resets to 0.
- Grant to `rvalid` latency is 2 + W cycles, where W is the number of cycles `mem_ack` stays low after `mem_req` rises:
  - grant in cycle N; `mem_req` high from N+1; `mem_ack` at the edge ending N+1+W; `rvalid` in N+2+W.
- The next grant can be issued in the same cycle as the previous `rvalid`, giving a throughput of one transaction per 2 + W cycles.
- `busy` = state ≠ IDLE, registered.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A wait counter clears on each grant and increments every BUSY cycle with `mem_ack` low.
  - When the count reaches `TIMEOUT` without `mem_ack`, the FSM goes to IDLE, `mem_req` drops and `err` pulses for one cycle.
  - The owner's `rvalid` pulses in the same cycle as `err`, with `i_rdata = 32'h0000_0013` or `d_rdata = 0`. A store is reported complete but is not guaranteed to have been written.
  - `mem_ack` arriving at the timeout edge wins: the transaction completes normally and there is no `err`.
- `ARB_TIMEOUT_EN` undefined: no wait counter; `err` is tied 0 and the arbiter waits indefinitely.

## Test plan
- Single fetch, zero-wait memory: `i_req`, `i_addr = 0x10` in cycle 0 → `i_gnt` in cycle 0; `mem_req` with `mem_addr = 0x10` in cycle 1; `mem_ack` with `mem_rdata = 0x00500093` in cycle 1 → `i_rvalid`, `i_rdata = 0x00500093` in cycle 2.
- Store with W = 3: `d_we = 1`, `d_addr = 0x100`, `d_wdata = 0xDEADBEEF`, `d_be = 4'b1111` → `mem_req` high for 4 cycles with a stable payload; `d_rvalid` 1 cycle after the ack; `d_rdata` unchanged.
- Contention, `STARVE_MAX = 4`: `i_req` and `d_req` both held high continuously → grant order D, D, D, D, I, D, D, D, D, I.
- Reset mid-transaction: `rst` low during BUSY_D with W = 5 → `mem_req` and `busy` drop asynchronously, no `d_rvalid`; after release, a new `i_req` is granted in the first IDLE cycle.
- Late ack: `mem_ack` asserted during IDLE is ignored (no `rvalid`, no state change); simultaneous new requests are still arbitrated normally.
- `ARB_TIMEOUT_EN`, `TIMEOUT = 8`, fetch with no ack → `err` and `i_rvalid` together, `i_rdata = 0x00000013`; the next request is granted normally. Also check an ack exactly at count 8 → normal completion, no `err`.
